// File: rtl/a_mult_prep_if.sv
`default_nettype none
// ============================================================================
// Module   : a_mult_prep_if
// Function : Input pair and output multiples handshake bundle for a_mult_prep
// Revision : 1.0 - initial release
// ============================================================================
interface a_mult_prep_if;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_a;
    logic [3:0]  in_s;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] a;
    logic [12:0] ax2;
    logic [12:0] ax3;
    logic [12:0] ax4;
    logic [3:0]  s;
    logic [7:0]  idx;
    logic        last;
    logic        err;

    modport slave (
        input  in_valid, in_a, in_s, out_ready,
        output in_ready, out_valid, a, ax2, ax3, ax4, s, idx, last, err
    );

    modport master (
        output in_valid, in_a, in_s, out_ready,
        input  in_ready, out_valid, a, ax2, ax3, ax4, s, idx, last, err
    );
endinterface
`default_nettype wire

// File: rtl/a_mult_prep.sv
`default_nettype none
// ============================================================================
// Module   : a_mult_prep
// Function : Precomputes a, 2a, 3a, 4a and a sign-magnitude secret per
//            coefficient, buffered in a 2-entry FIFO with frame indexing.
// Revision : 1.0 - initial release
// ============================================================================
module a_mult_prep #(
    parameter int N_COEFF = 256
) (
    input  wire logic     clk,
    input  wire logic     rst,
    a_mult_prep_if.slave  bus
);
    localparam logic [7:0] c_last_idx = 8'(N_COEFF - 1);

    logic [12:0] r_a   [2];
    logic [12:0] r_ax2 [2];
    logic [12:0] r_ax3 [2];
    logic [12:0] r_ax4 [2];
    logic [3:0]  r_s   [2];
    logic [7:0]  r_idx [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [7:0]  r_wr_idx;
    logic        r_err;

    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_push;
    logic        w_pop;
    logic [12:0] w_ax2;
    logic [12:0] w_ax3;
    logic [12:0] w_ax4;
    logic [3:0]  w_s_abs;
    logic        w_s_legal;
    logic [3:0]  w_s_sm;

    // Handshake decoded from registered occupancy only
    assign w_in_ready  = (r_count < 2'd2);
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    assign w_ax2 = {bus.in_a[11:0], 1'b0};
    assign w_ax4 = {bus.in_a[10:0], 2'b00};
    assign w_ax3 = bus.in_a + w_ax2;

    // Legal secrets are -4..+4; 4'hC is -4 in two's complement
    assign w_s_abs   = bus.in_s[3] ? (4'd0 - bus.in_s) : bus.in_s;
    assign w_s_legal = bus.in_s[3] ? (bus.in_s >= 4'hC) : (bus.in_s <= 4'h4);
    assign w_s_sm    = w_s_legal ? {bus.in_s[3], w_s_abs[2:0]} : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_a[i]   <= '0;
                r_ax2[i] <= '0;
                r_ax3[i] <= '0;
                r_ax4[i] <= '0;
                r_s[i]   <= '0;
                r_idx[i] <= '0;
            end
        end else if (w_push) begin
            r_a[r_wr_ptr]   <= bus.in_a;
            r_ax2[r_wr_ptr] <= w_ax2;
            r_ax3[r_wr_ptr] <= w_ax3;
            r_ax4[r_wr_ptr] <= w_ax4;
            r_s[r_wr_ptr]   <= w_s_sm;
            r_idx[r_wr_ptr] <= r_wr_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_wr_idx <= 8'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
                r_wr_idx <= (r_wr_idx == c_last_idx) ? 8'd0 : r_wr_idx + 8'd1;
                if (!w_s_legal) begin
                    r_err <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.a         = r_a[r_rd_ptr];
    assign bus.ax2       = r_ax2[r_rd_ptr];
    assign bus.ax3       = r_ax3[r_rd_ptr];
    assign bus.ax4       = r_ax4[r_rd_ptr];
    assign bus.s         = r_s[r_rd_ptr];
    assign bus.idx       = r_idx[r_rd_ptr];
    assign bus.last      = (r_idx[r_rd_ptr] == c_last_idx);
    assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_a_mult_prep.sv
`default_nettype none
// ============================================================================
// Module   : tb_a_mult_prep
// Function : Directed self-checking bench for a_mult_prep with a queue model
// Revision : 1.0 - initial release
// ============================================================================
module tb_a_mult_prep;
    localparam int N = 256;

    typedef struct {
        int a;
        int ax2;
        int ax3;
        int ax4;
        int s;
        int idx;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    a_mult_prep_if bus_if ();

    a_mult_prep #(.N_COEFF(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    ent_t q[$];
    int   m_idx = 0;
    bit   m_err = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of up to two pending pairs, updated for the coming edge
    always @(negedge clk) begin
        int   sz;
        int   v;
        ent_t e;
        bit   push;
        bit   pop;
        if (rst) begin
            q.delete();
            m_idx = 0;
            m_err = 1'b0;
            chk("rst_in_ready", bus_if.in_ready, 1);
            chk("rst_out_valid", bus_if.out_valid, 0);
            chk("rst_a", bus_if.a, 0);
            chk("rst_ax2", bus_if.ax2, 0);
            chk("rst_ax3", bus_if.ax3, 0);
            chk("rst_ax4", bus_if.ax4, 0);
            chk("rst_s", bus_if.s, 0);
            chk("rst_idx", bus_if.idx, 0);
            chk("rst_last", bus_if.last, 0);
            chk("rst_err", bus_if.err, 0);
        end else begin
            sz = q.size();
            chk("in_ready", bus_if.in_ready, (sz < 2) ? 1 : 0);
            chk("out_valid", bus_if.out_valid, (sz > 0) ? 1 : 0);
            chk("err", bus_if.err, m_err ? 1 : 0);
            if (sz > 0) begin
                chk("a", bus_if.a, q[0].a);
                chk("ax2", bus_if.ax2, q[0].ax2);
                chk("ax3", bus_if.ax3, q[0].ax3);
                chk("ax4", bus_if.ax4, q[0].ax4);
                chk("s", bus_if.s, q[0].s);
                chk("idx", bus_if.idx, q[0].idx);
                chk("last", bus_if.last, (q[0].idx == N - 1) ? 1 : 0);
            end
            push = bus_if.in_valid && (sz < 2);
            pop  = (sz > 0) && bus_if.out_ready;
            if (pop) void'(q.pop_front());
            if (push) begin
                e.a   = int'(bus_if.in_a);
                e.ax2 = (e.a * 2) % 8192;
                e.ax3 = (e.a * 3) % 8192;
                e.ax4 = (e.a * 4) % 8192;
                v     = int'($signed(bus_if.in_s));
                if (v >= -4 && v <= 4) begin
                    e.s = (v < 0) ? 8 - v : v;
                end else begin
                    e.s   = 0;
                    m_err = 1'b1;
                end
                e.idx = m_idx;
                q.push_back(e);
                m_idx = (m_idx + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int av, input int sv);
        bus_if.in_valid = 1'b1;
        bus_if.in_a     = 13'(av);
        bus_if.in_s     = 4'(sv);
    endtask

    task automatic drive_rand();
        drive(int'($urandom_range(0, 8191)), int'($urandom_range(0, 8)) - 4);
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = '0;
        bus_if.in_s      = '0;
        bus_if.out_ready = 1'b0;
        repeat (3) step();
        chk("lit_rst_in_ready", bus_if.in_ready, 1);
        chk("lit_rst_out_valid", bus_if.out_valid, 0);
        rst = 1'b0;
        step();

        // 1FFF * {1,2,3,4} mod 2^13 and -3 -> sign-magnitude 1011
        bus_if.out_ready = 1'b1;
        drive(13'h1FFF, -3);
        step();
        bus_if.in_valid = 1'b0;
        chk("lit_out_valid", bus_if.out_valid, 1);
        chk("lit_a", bus_if.a, 13'h1FFF);
        chk("lit_ax2", bus_if.ax2, 13'h1FFE);
        chk("lit_ax3", bus_if.ax3, 13'h1FFD);
        chk("lit_ax4", bus_if.ax4, 13'h1FFC);
        chk("lit_s", bus_if.s, 4'b1011);
        chk("lit_idx", bus_if.idx, 0);
        step();

        for (int v = -4; v <= 4; v++) begin
            drive(int'($urandom_range(0, 8191)), v);
            step();
        end
        chk("lit_s_plus4", bus_if.s, 4'b0100);
        bus_if.in_valid = 1'b0;
        step();

        // Backpressure: two accepted, third held off until a pop
        bus_if.out_ready = 1'b0;
        drive(13'h0111, 1);
        step();
        drive(13'h0222, -2);
        step();
        chk("lit_full_in_ready", bus_if.in_ready, 0);
        chk("lit_hold_a", bus_if.a, 13'h0111);
        drive(13'h0333, 3);
        step();
        step();
        chk("lit_full_in_ready2", bus_if.in_ready, 0);
        chk("lit_hold_a2", bus_if.a, 13'h0111);
        bus_if.out_ready = 1'b1;
        step();
        chk("lit_after_pop_a", bus_if.a, 13'h0222);
        step();
        chk("lit_pushpop_a", bus_if.a, 13'h0333);
        chk("lit_pushpop_ax3", bus_if.ax3, 13'h0999);
        bus_if.in_valid = 1'b0;
        step();

        // Illegal secret: stored as zero, err sticky
        drive(5, 6);
        step();
        chk("lit_illegal_s", bus_if.s, 0);
        chk("lit_err_set", bus_if.err, 1);
        drive(100, 3);
        step();
        chk("lit_err_sticky", bus_if.err, 1);
        drive(7, -8);
        step();
        drive(9, -5);
        step();
        drive(11, 7);
        step();
        drive(12, -1);
        step();
        bus_if.in_valid = 1'b0;
        step();

        rst = 1'b1;
        step();
        chk("lit_err_cleared", bus_if.err, 0);
        rst = 1'b0;
        step();

        // Stream to idx 99, then reset asynchronously mid-frame
        for (int i = 0; i < 100; i++) begin
            drive_rand();
            step();
        end
        chk("lit_idx99", bus_if.idx, 99);
        #2;
        rst = 1'b1;
        #1;
        chk("lit_async_out_valid", bus_if.out_valid, 0);
        chk("lit_async_in_ready", bus_if.in_ready, 1);
        bus_if.in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Full frame plus one: idx wraps after 255, last only at 255
        for (int i = 0; i <= N; i++) begin
            drive_rand();
            step();
            if (i == 0) chk("lit_first_idx", bus_if.idx, 0);
            if (i == N - 2) chk("lit_last_early", bus_if.last, 0);
            if (i == N - 1) begin
                chk("lit_idx255", bus_if.idx, 255);
                chk("lit_last", bus_if.last, 1);
            end
            if (i == N) begin
                chk("lit_wrap_idx", bus_if.idx, 0);
                chk("lit_wrap_last", bus_if.last, 0);
            end
        end
        bus_if.in_valid = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/a_mult_prep.md
A_MULT_PREP -- requirements
Module: a_mult_prep

Interface
- REQ-001: Parameter N_COEFF, default 256; number of coefficients per polynomial frame; legal range 2..256.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: in_valid  input  1  upstream offers a coefficient pair.
- REQ-005: in_ready  output  1  block accepts a pair this cycle.
- REQ-006: in_a  input  13  public-polynomial coefficient, unsigned, mod 2^13.
- REQ-007: in_s  input  4  secret coefficient, two's complement; legal range -4..+4.
- REQ-008: out_valid  output  1  output pair available.
- REQ-009: out_ready  input  1  downstream multiply-accumulate stage consumes the pair.
- REQ-010: a, ax2, ax3, ax4  output  13 each  a, 2a, 3a, 4a, each mod 2^13.
- REQ-011: s  output  4  sign-magnitude secret: bit 3 is the sign (1 = subtract), bits 2:0 are the magnitude 0..4.
- REQ-012: idx  output  8  coefficient index of the output pair, 0..N_COEFF-1.
- REQ-013: last  output  1  high while the output pair is the frame's final coefficient (idx == N_COEFF-1).
- REQ-014: err  output  1  sticky flag for an illegal secret coefficient.

Function
- REQ-015: The block SHALL hold a 2-entry FIFO; each entry stores a, ax2, ax3, ax4, s and idx.
- REQ-016: A push SHALL occur on a clk edge where in_valid && in_ready; a pop SHALL occur on a clk edge where out_valid && out_ready.
- REQ-017: in_ready SHALL equal (count < 2), decoded from registered count only, with no combinational path from out_ready.
- REQ-018: out_valid SHALL equal (count > 0); the outputs SHALL present the head entry and SHALL hold stable while out_valid && !out_ready.
- REQ-019: Latency SHALL be 1 cycle: a pair pushed into an empty FIFO appears at the outputs in the following cycle.
- REQ-020: Simultaneous push and pop at count 1 SHALL leave count at 1 and keep order; at count 2 no push is possible; at count 0 no pop is possible.
- REQ-021: Multiples SHALL be computed at push time: ax2 = a<<1, ax4 = a<<2, ax3 = a + (a<<1), each truncated to 13 bits.
- REQ-022: Sign-magnitude conversion SHALL map in_s = v in -4..+4 to s = {v<0, |v|}; v = 0 SHALL give s = 4'b0000.
- REQ-023: An illegal in_s (-8..-5 or +5..+7) SHALL store s = 4'b0000 for that entry and set err at the push edge; err stays 1 until reset.
- REQ-024: A write index counter SHALL hold the idx of the next push; it increments on each push and wraps from N_COEFF-1 to 0.
- REQ-025: last SHALL be derived from the head entry's stored idx.
- REQ-026: FIFO read and write pointers SHALL be 1 bit each and wrap modulo 2.

Reset
- REQ-027: While rst is high: count = 0, pointers = 0, index counter = 0, err = 0, in_ready = 1, out_valid = 0.
- REQ-028: Also while rst is high: a, ax2, ax3, ax4, s, idx = 0 and last = 0.
- REQ-029: Reset asserted mid-frame SHALL discard all buffered entries; the first push after release SHALL carry idx 0.

Verification
- REQ-030: Push in_a=13'h1FFF, in_s=-3 with out_ready=1 -> next cycle out_valid=1, a=1FFF, ax2=1FFE, ax3=1FFD, ax4=1FFC, s=4'b1011, idx=0.
- REQ-031: Hold out_ready=0, push 3 pairs -> in_ready low after 2 pushes; outputs hold the first pair; the third pair is not accepted until a pop.
- REQ-032: Stream N_COEFF=256 pairs continuously with out_ready=1 -> one pair per cycle, idx runs 0..255, last is high only at idx 255, and the next pair has idx 0.
- REQ-033: Push in_s=+6 -> s=0000 for that pair, err=1 from the next cycle, err stays 1 across later legal pushes until rst.
- REQ-034: With count 1, push and pop in the same cycle -> count stays 1 and the outputs show the newly pushed pair next cycle.
- REQ-035: Assert rst asynchronously mid-frame at idx 100 -> out_valid=0 immediately, in_ready=1, and the next push after release has idx 0.
